// File: rtl/bus_pkg.sv
// Shared D-bus types: transfer type, transfer size and the arbiter state.
package bus_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } tsize_t;

  // busy on the arbiter is the external view of this state (busy == ACTIVE).
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request at or
// after ptr_i, wrapping N-1 -> 0. Shared between the D-bus and I-bus arbiters.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [N-1:0]  req_rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Rotate so the pointer position sits at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    req_rot = N'({req_i, req_i} >> ptr_i);
    valid_o = |req_rot;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    idx_o = sum[IW-1:0];
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one D-bus slave path between
// NUM_MASTERS masters, one transaction in flight.
// Optional feature: define DBUS_ARB_TIMEOUT_EN to abort ACTIVE after
// TIMEOUT_CYCLES cycles without s_bdone (m_bdone + m_berr pulse, m_rdata = 0).
//
// Handshake: a master holds m_bstart until it sees its m_bdone pulse. The
// arbiter holds s_bstart with stable s_* fields until the one-cycle s_bdone
// pulse; m_bdone/m_rdata are a same-cycle combinational echo of s_bdone.
module dbus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_MASTERS-1:0]             m_bstart,
  input  logic [NUM_MASTERS-1:0][31:0]       m_addr,
  input  logic [NUM_MASTERS-1:0]             m_ttype,
  input  logic [NUM_MASTERS-1:0][1:0]        m_tsize,
  input  logic [NUM_MASTERS-1:0][31:0]       m_wdata,
  output logic [NUM_MASTERS-1:0]             m_bdone,
  output logic [NUM_MASTERS-1:0]             m_berr,
  output logic [31:0]                        m_rdata,
  output logic                               s_bstart,
  output logic [31:0]                        s_addr,
  output ttype_t                             s_ttype,
  output tsize_t                             s_tsize,
  output logic [31:0]                        s_wdata,
  input  logic                               s_bdone,
  input  logic [31:0]                        s_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0]     grant_id,
  output logic                               busy
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("dbus_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [31:0]       addr_q, addr_d;
  ttype_t            ttype_q, ttype_d;
  tsize_t            tsize_q, tsize_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              done_ok;
  logic              abort;
  logic              finish;
  logic [NUM_MASTERS-1:0] grant_oh;

  rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
    .req_i   (m_bstart),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter is held at zero in IDLE so every ACTIVE period starts from zero.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE)  tmo_cnt_d = '0;
    else if (!finish)     tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  // A real completion in the last allowed cycle takes priority over the abort.
  assign abort = (state_q == ACTIVE) && !s_bdone && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // Completion decode and combinational echo back to the granted master.
  always_comb begin
    done_ok  = (state_q == ACTIVE) && s_bdone;
    finish   = done_ok || abort;
    grant_oh = NUM_MASTERS'(1) << grant_q;
    m_bdone  = finish ? grant_oh : '0;
    m_berr   = abort  ? grant_oh : '0;
    m_rdata  = done_ok ? s_rdata : '0;
  end

  // Next-state: arbitrate and latch in IDLE, release and advance the pointer on completion.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    ttype_d = ttype_q;
    tsize_d = tsize_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACTIVE;
          grant_d = pick_idx;
          addr_d  = m_addr[pick_idx];
          ttype_d = ttype_t'(m_ttype[pick_idx]);
          tsize_d = tsize_t'(m_tsize[pick_idx]);
          wdata_d = m_wdata[pick_idx];
        end
      end
      ACTIVE: begin
        if (finish) begin
          state_d = IDLE;
          ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      ttype_q <= READ;
      tsize_q <= WORD;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      ttype_q <= ttype_d;
      tsize_q <= tsize_d;
      wdata_q <= wdata_d;
    end
  end

  assign s_bstart = (state_q == ACTIVE);
  assign busy     = (state_q == ACTIVE);
  assign s_addr   = addr_q;
  assign s_ttype  = ttype_q;
  assign s_tsize  = tsize_q;
  assign s_wdata  = wdata_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios followed by a randomized phase,
// all checked every cycle against a transaction-level reference model.
module tb_dbus_arbiter;
  import bus_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 64;
  localparam int IW  = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]       m_bstart;
  logic [N-1:0][31:0] m_addr;
  logic [N-1:0]       m_ttype;
  logic [N-1:0][1:0]  m_tsize;
  logic [N-1:0][31:0] m_wdata;
  logic [N-1:0]       m_bdone;
  logic [N-1:0]       m_berr;
  logic [31:0]        m_rdata;
  logic               s_bstart;
  logic [31:0]        s_addr;
  ttype_t             s_ttype;
  tsize_t             s_tsize;
  logic [31:0]        s_wdata;
  logic               s_bdone;
  logic [31:0]        s_rdata;
  logic [IW-1:0]      grant_id;
  logic               busy;

  dbus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_bstart (m_bstart),
    .m_addr   (m_addr),
    .m_ttype  (m_ttype),
    .m_tsize  (m_tsize),
    .m_wdata  (m_wdata),
    .m_bdone  (m_bdone),
    .m_berr   (m_berr),
    .m_rdata  (m_rdata),
    .s_bstart (s_bstart),
    .s_addr   (s_addr),
    .s_ttype  (s_ttype),
    .s_tsize  (s_tsize),
    .s_wdata  (s_wdata),
    .s_bdone  (s_bdone),
    .s_rdata  (s_rdata),
    .grant_id (grant_id),
    .busy     (busy)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];   // expected order of granted master ids
  bit          prev_bs = 1'b0;
  int          berr_seen = 0;
  bit [N-1:0]  keep_req = '0;

  // Reference model: one in-flight transaction, pointer as a plain integer.
  bit          mb;
  int          mg, mptr, mcnt;
  logic [31:0] maddr, mwd;
  logic        mtt;
  logic [1:0]  mts;
  bit [N-1:0]  done_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mb = 1'b0; mg = 0; mptr = 0; mcnt = 0;
    maddr = '0; mwd = '0; mtt = 1'b0; mts = 2'd2;
    done_flag = '0;
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit tmo_now();
`ifdef DBUS_ARB_TIMEOUT_EN
    return mb && !s_bdone && (mcnt == TMO - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle just ended.
  task automatic model_edge();
    int g;
    done_flag = '0;
    if (!rst_n) begin
      model_reset();
    end else if (mb) begin
      if (s_bdone || tmo_now()) begin
        mb = 1'b0;
        done_flag[mg] = 1'b1;
        mptr = (mg + 1) % N;
      end else begin
        mcnt++;
      end
    end else begin
      g = pick(m_bstart, mptr);
      if (g >= 0) begin
        mb = 1'b1; mg = g; mcnt = 0;
        maddr = m_addr[g]; mwd = m_wdata[g]; mtt = m_ttype[g]; mts = m_tsize[g];
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] oh;
    bit tmo;
    tmo = tmo_now();
    oh  = 32'(1) << mg;
    chk("s_bstart", 32'(s_bstart), 32'(mb));
    chk("busy",     32'(busy),     32'(mb));
    chk("grant_id", 32'(grant_id), 32'(mg));
    chk("s_addr",   s_addr,        maddr);
    chk("s_ttype",  32'(s_ttype),  32'(mtt));
    chk("s_tsize",  32'(s_tsize),  32'(mts));
    chk("s_wdata",  s_wdata,       mwd);
    chk("m_bdone",  32'(m_bdone),  (mb && (s_bdone || tmo)) ? oh : 32'd0);
    chk("m_berr",   32'(m_berr),   (mb && tmo) ? oh : 32'd0);
    chk("m_rdata",  m_rdata,       (mb && s_bdone) ? s_rdata : 32'd0);
    if (m_berr != '0) berr_seen++;
    if (s_bstart && !prev_bs && exp_q.size() != 0) chk("grant_order", 32'(grant_id), exp_q.pop_front());
    prev_bs = s_bstart;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: check mid-cycle, step the model at the edge, then let masters react.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      if (done_flag[i] && !keep_req[i]) m_bstart[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic tt, input logic [1:0] ts,
                         input logic [31:0] a, input logic [31:0] d);
    m_addr[i] = a; m_ttype[i] = tt; m_tsize[i] = ts; m_wdata[i] = d;
    m_bstart[i] = 1'b1;
  endtask

  // Slave answers on the lat-th cycle of the current ACTIVE period.
  task automatic serve(input int lat, input logic [31:0] data);
    s_bdone = 1'b0;
    repeat (lat - 1) cycle();
    s_rdata = data; s_bdone = 1'b1;
    cycle();
    s_bdone = 1'b0; s_rdata = $urandom;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_bstart", 32'(s_bstart), 32'd0);
    chk("async_rst_busy",   32'(busy),     32'd0);
    cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_bstart = '0; m_addr = '0; m_ttype = '0; m_tsize = '0; m_wdata = '0;
    s_bdone = 1'b0; s_rdata = '0;
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;

    // Single read from m0, slave answers on the third ACTIVE cycle.
    exp_q.push_back(0);
    set_req(0, READ, WORD, 32'h0000_0100, 32'h0);
    cycle();
    serve(3, 32'hDEAD_BEEF);
    cycle();

    // Simultaneous m0+m1 straight after reset: m0 then m1.
    sync_reset();
    exp_q.push_back(0); exp_q.push_back(1);
    set_req(0, READ,  WORD, 32'h0000_0200, 32'h0);
    set_req(1, WRITE, BYTE, 32'h0000_0301, 32'hA5);
    cycle(); serve(2, $urandom);
    cycle(); serve(2, $urandom);
    cycle();

    // Both requesting continuously: strict alternation over 8 transactions.
    keep_req = '1;
    set_req(0, READ,  HALFWORD, 32'h0000_1000, 32'h0);
    set_req(1, WRITE, WORD,     32'h0000_2000, 32'h5555_AAAA);
    for (int t = 0; t < 8; t++) begin
      exp_q.push_back(32'(t % 2));
      cycle();
      serve($urandom_range(1, 4), $urandom);
    end
    keep_req = '0;
    m_bstart = '0;
    cycle();

    // m1 write in flight, m0 arrives during ACTIVE; fields must not move, m0 next.
    exp_q.push_back(1); exp_q.push_back(0);
    set_req(1, WRITE, HALFWORD, 32'h8000_0002, 32'h0000_1234);
    cycle(); cycle();
    set_req(0, READ, BYTE, 32'h0000_0040, 32'h0);
    m_addr[1] = 32'hFFFF_FFFF; m_wdata[1] = 32'h0BAD_0BAD;
    cycle(); cycle();
    serve(1, $urandom);
    cycle(); serve(2, $urandom);
    cycle();

    // Async reset mid-transaction; both pending afterwards, pointer back at 0.
    exp_q.push_back(1);
    set_req(1, READ, WORD, 32'h0000_0500, 32'h0);
    cycle(); cycle();
    set_req(0, WRITE, WORD, 32'h0000_0600, 32'h1111_2222);
    cycle();
    async_reset();
    exp_q.push_back(0);
    cycle(); serve(2, $urandom);
    exp_q.push_back(1);
    cycle(); serve(2, $urandom);
    cycle();

`ifdef DBUS_ARB_TIMEOUT_EN
    // Silent slave: abort with berr, then a normal transaction.
    berr_seen = 0;
    exp_q.push_back(0);
    set_req(0, READ, WORD, 32'h0000_0700, 32'h0);
    cycle();
    repeat (TMO) cycle();
    cycle();
    chk("timeout_berr_pulses", 32'(berr_seen), 32'd1);
    exp_q.push_back(1);
    set_req(1, READ, WORD, 32'h0000_0800, 32'h0);
    cycle(); serve(2, $urandom);
    cycle();
`else
    chk("berr_never", 32'(berr_seen), 32'd0);
`endif

    // Randomized traffic: random requests, random slave pulses (also in IDLE), occasional mid-transfer drops.
    for (int c = 0; c < 400; c++) begin
      s_bdone = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      for (int i = 0; i < N; i++) begin
        if (!m_bstart[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      end
      if (mb && $urandom_range(0, 15) == 0) m_bstart[mg] = 1'b0;
      cycle();
    end
    s_bdone = 1'b0;
    m_bstart = '0;
    cycle(); cycle();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
